// File: rtl/ram_erase_ctl.sv
// ram_erase_ctl: AXI4 write master that fills one RAM bank with FILL_VALUE after an erase_ram strobe.
// Define RAM_ERASE_ERRCNT_EN to build the saturating error_count; otherwise error_count reads 0.
module ram_erase_ctl #(
  parameter int unsigned DW          = 512,
  parameter int unsigned AW          = 34,
  parameter logic [63:0] RAM_BASE    = 64'h0,
  parameter logic [63:0] RAM_SIZE    = 64'h2_0000_0000,
  parameter int unsigned BURST_BEATS = 64,
  parameter int unsigned MAX_OUT     = 8,
  parameter logic [31:0] FILL_VALUE  = 32'h0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            erase_ram,
  output logic            erase_idle,
  output logic            erase_error,
  output logic [31:0]     error_count,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY
);
  localparam int unsigned       CNT_W     = 32;
  localparam int unsigned       BEAT_W    = 8;
  localparam logic [63:0]       BB        = 64'(BURST_BEATS) * 64'(DW / 8);
  localparam logic [CNT_W-1:0]  N         = CNT_W'(RAM_SIZE / BB);
  localparam logic [CNT_W-1:0]  MAX_OUT_C = CNT_W'(MAX_OUT);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  aw_cnt, aw_cnt_n, w_cnt, w_cnt_n, b_cnt, b_cnt_n;
  logic [BEAT_W-1:0] beat, beat_n;
  logic [AW-1:0]     awaddr_n;
  logic              awvalid_n, wvalid_n, wlast_n, bready_n, idle_n, error_n;
  logic              aw_hs, w_hs, b_hs, b_err;

  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WDATA   = {(DW / 32){FILL_VALUE}};

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID & M_AXI_BREADY;
  assign b_err = b_hs & (M_AXI_BRESP != 2'b00);

  // Next-state and next-output logic; every AXI output is taken from a register.
  always_comb begin
    state_n   = state;
    aw_cnt_n  = aw_cnt;
    w_cnt_n   = w_cnt;
    b_cnt_n   = b_cnt;
    beat_n    = beat;
    awaddr_n  = M_AXI_AWADDR;
    error_n   = erase_error;
    awvalid_n = 1'b0;
    wvalid_n  = 1'b0;
    wlast_n   = 1'b0;
    bready_n  = 1'b0;
    idle_n    = 1'b1;
    case (state)
      IDLE: begin
        if (erase_ram) begin
          aw_cnt_n = '0;
          w_cnt_n  = '0;
          b_cnt_n  = '0;
          beat_n   = '0;
          awaddr_n = AW'(RAM_BASE);
          error_n  = 1'b0;
          if (N != '0) state_n = RUN;
        end
      end
      RUN: begin
        aw_cnt_n = aw_cnt + CNT_W'(aw_hs);
        b_cnt_n  = b_cnt + CNT_W'(b_hs);
        if (aw_hs) awaddr_n = M_AXI_AWADDR + AW'(BB);
        if (w_hs) begin
          if (M_AXI_WLAST) begin
            beat_n  = '0;
            w_cnt_n = w_cnt + CNT_W'(1);
          end else begin
            beat_n = beat + BEAT_W'(1);
          end
        end
        if (b_err) error_n = 1'b1;
        if (b_cnt_n == N) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A stalled VALID is held; otherwise VALID follows the post-update counters.
    if (state_n == RUN) begin
      idle_n    = 1'b0;
      bready_n  = 1'b1;
      awvalid_n = (M_AXI_AWVALID && !M_AXI_AWREADY) ||
                  ((aw_cnt_n < N) && ((aw_cnt_n - b_cnt_n) < MAX_OUT_C));
      wvalid_n  = (M_AXI_WVALID && !M_AXI_WREADY) || (w_cnt_n < aw_cnt_n);
      wlast_n   = wvalid_n && (beat_n == LAST_BEAT);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      aw_cnt        <= '0;
      w_cnt         <= '0;
      b_cnt         <= '0;
      beat          <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_WLAST   <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      erase_idle    <= 1'b1;
      erase_error   <= 1'b0;
    end else begin
      state         <= state_n;
      aw_cnt        <= aw_cnt_n;
      w_cnt         <= w_cnt_n;
      b_cnt         <= b_cnt_n;
      beat          <= beat_n;
      M_AXI_AWADDR  <= awaddr_n;
      M_AXI_AWVALID <= awvalid_n;
      M_AXI_WVALID  <= wvalid_n;
      M_AXI_WLAST   <= wlast_n;
      M_AXI_BREADY  <= bready_n;
      erase_idle    <= idle_n;
      erase_error   <= error_n;
    end
  end

`ifdef RAM_ERASE_ERRCNT_EN
  logic [31:0] err_cnt, err_cnt_n;

  // Saturating count of non-OKAY write responses, cleared on each start.
  always_comb begin
    err_cnt_n = err_cnt;
    if ((state == IDLE) && erase_ram) begin
      err_cnt_n = '0;
    end else if ((state == RUN) && b_err && (err_cnt != '1)) begin
      err_cnt_n = err_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_cnt <= '0;
    else         err_cnt <= err_cnt_n;
  end

  assign error_count = err_cnt;
`else
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_ram_erase_ctl.sv
// Bench for ram_erase_ctl: scenario table with randomized READY/B timing checked against a sweep model,
// plus hand-written reset-mid-sweep and single-outstanding sequences.
module tb_ram_erase_ctl;
  localparam int unsigned DW    = 512;
  localparam int unsigned AW    = 34;
  localparam int unsigned BEATS = 4;
  localparam logic [63:0] BASE  = 64'h1000;
  localparam logic [63:0] SIZE  = 64'd1024;
  localparam int unsigned BB    = BEATS * DW / 8;
  localparam int unsigned NB    = 1024 / BB;
  localparam int unsigned MAXO  = 8;
  localparam logic [31:0] FILL  = 32'hA5C3_0F1E;
`ifdef RAM_ERASE_ERRCNT_EN
  localparam int ERRCNT_ON = 1;
`else
  localparam int ERRCNT_ON = 0;
`endif

  logic clk, resetn, erase_ram, awready, wready, bvalid;
  logic [1:0] bresp;
  logic erase_idle, erase_error, awvalid, wvalid, wlast, bready;
  logic [31:0] error_count;
  logic [AW-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;

  logic erase_ram1, awready1, wready1, bvalid1;
  logic [1:0] bresp1;
  logic erase_idle1, erase_error1, awvalid1, wvalid1, wlast1, bready1;
  logic [31:0] error_count1;
  logic [AW-1:0] awaddr1;
  logic [7:0] awlen1;
  logic [2:0] awsize1;
  logic [1:0] awburst1;
  logic [DW-1:0] wdata1;
  logic [DW/8-1:0] wstrb1;

  ram_erase_ctl #(.DW(DW), .AW(AW), .RAM_BASE(BASE), .RAM_SIZE(SIZE), .BURST_BEATS(BEATS),
                  .MAX_OUT(MAXO), .FILL_VALUE(FILL)) dut (
    .clk(clk), .resetn(resetn), .erase_ram(erase_ram), .erase_idle(erase_idle),
    .erase_error(erase_error), .error_count(error_count),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready));

  ram_erase_ctl #(.DW(DW), .AW(AW), .RAM_BASE(BASE), .RAM_SIZE(SIZE), .BURST_BEATS(BEATS),
                  .MAX_OUT(1), .FILL_VALUE(FILL)) dut1 (
    .clk(clk), .resetn(resetn), .erase_ram(erase_ram1), .erase_idle(erase_idle1),
    .erase_error(erase_error1), .error_count(error_count1),
    .M_AXI_AWADDR(awaddr1), .M_AXI_AWLEN(awlen1), .M_AXI_AWSIZE(awsize1), .M_AXI_AWBURST(awburst1),
    .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(awready1),
    .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WLAST(wlast1), .M_AXI_WVALID(wvalid1),
    .M_AXI_WREADY(wready1), .M_AXI_BRESP(bresp1), .M_AXI_BVALID(bvalid1), .M_AXI_BREADY(bready1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit stall;
    int err_burst;
    int restrobe;
    int exp_aw;
    int exp_beats;
    bit exp_err;
    int exp_errcnt;
  } vec_t;

  vec_t vecs[6];
  int checks, errors;
  int cyc;
  bit stall;
  int err_burst;
  logic [DW-1:0] exp_wdata;

  // Sweep model: per-sweep handshake counts, activity, error state, hold tracking.
  bit m_active, m_err, just_started;
  int m_errcnt;
  int sw_aw, sw_w, sw_b, sw_bissued;
  bit hold_aw, hold_w, hold_wlast;
  logic [AW-1:0] hold_addr;
  bit aw_f, w_f, b_f, wlast_f;
  int bq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Runs at the falling edge: checks outputs, then records handshakes of the coming rising edge.
  task automatic monitor();
    bit was_active;
    if (!resetn) begin
      m_active = 1'b0; hold_aw = 1'b0; hold_w = 1'b0;
      aw_f = 1'b0; w_f = 1'b0; b_f = 1'b0; wlast_f = 1'b0;
      return;
    end
    was_active = m_active;
    aw_f = awvalid && awready;
    w_f  = wvalid && wready;
    b_f  = bready && bvalid;
    wlast_f = w_f && wlast;
    check("erase_idle", 64'(erase_idle), 64'(!m_active));
    check("erase_error", 64'(erase_error), 64'(m_err));
    check("error_count", 64'(error_count), 64'(ERRCNT_ON != 0 ? m_errcnt : 0));
    if (just_started) begin
      check("awvalid_after_start", 64'(awvalid), 64'(1));
      check("wvalid_after_start", 64'(wvalid), 64'(0));
      just_started = 1'b0;
    end
    if (hold_aw) check("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, hold_addr}));
    if (hold_w)  check("w_hold", 64'({wvalid, wlast}), 64'({1'b1, hold_wlast}));
    hold_aw = awvalid && !awready;
    hold_addr = awaddr;
    hold_w = wvalid && !wready;
    hold_wlast = wlast;
    if (w_f) begin
      check("w_after_aw", 64'((sw_w / BEATS) < sw_aw), 64'(1));
      check("w_last", 64'(wlast), 64'((sw_w % BEATS) == BEATS - 1));
      check("w_data", 64'(wdata === exp_wdata), 64'(1));
      sw_w++;
    end
    if (aw_f) begin
      check("aw_addr", 64'(awaddr), BASE + 64'(sw_aw * BB));
      check("aw_outstanding", 64'((sw_aw - sw_b) < MAXO), 64'(1));
      check("aw_in_range", 64'(sw_aw < NB), 64'(1));
      sw_aw++;
    end
    if (b_f) begin
      if (bresp != 2'b00) begin
        m_err = 1'b1;
        m_errcnt++;
      end
      sw_b++;
      if (sw_b == NB) m_active = 1'b0;
    end
    if (!was_active && erase_ram) begin
      m_active = 1'b1; m_err = 1'b0; m_errcnt = 0; just_started = 1'b1;
      sw_aw = 0; sw_w = 0; sw_b = 0; sw_bissued = 0;
      bq.delete();
    end
  endtask

  // Runs just after the rising edge: slave side responses and READY randomization.
  task automatic drive();
    cyc++;
    if (b_f) bvalid = 1'b0;
    if (wlast_f) bq.push_back(cyc + (stall ? int'($urandom_range(0, 4)) : 0));
    if (!bvalid && bq.size() > 0 && cyc >= bq[0]) begin
      bvalid = 1'b1;
      bresp = (sw_bissued == err_burst) ? 2'b10 : 2'b00;
      sw_bissued++;
      bq.delete(0);
    end
    awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit done;
    stall = v.stall;
    err_burst = v.err_burst;
    erase_ram = 1'b1;
    step();
    erase_ram = 1'b0;
    n = 0;
    done = 1'b0;
    while (n < 2000 && !done) begin
      if (n == v.restrobe) erase_ram = 1'b1;
      step();
      erase_ram = 1'b0;
      n++;
      if (!m_active) done = 1'b1;
    end
    check($sformatf("v%0d_sweep_done", idx), 64'(done), 64'(1));
    step();
    step();
    check($sformatf("v%0d_aw_count", idx), 64'(sw_aw), 64'(v.exp_aw));
    check($sformatf("v%0d_beats", idx), 64'(sw_w), 64'(v.exp_beats));
    check($sformatf("v%0d_idle", idx), 64'(erase_idle), 64'(1));
    check($sformatf("v%0d_error", idx), 64'(erase_error), 64'(v.exp_err));
    check($sformatf("v%0d_errcnt", idx), 64'(error_count), 64'(v.exp_errcnt));
  endtask

  initial begin
    int n;
    int a1, b1;
    int q1[$];
    bit done1, af, wf, bf;

    vecs[0] = '{1'b0, -1, -1, 4, 16, 1'b0, 0};
    vecs[1] = '{1'b1, -1, -1, 4, 16, 1'b0, 0};
    vecs[2] = '{1'b0,  2, -1, 4, 16, 1'b1, ERRCNT_ON};
    vecs[3] = '{1'b0, -1, -1, 4, 16, 1'b0, 0};
    vecs[4] = '{1'b1, -1,  5, 4, 16, 1'b0, 0};
    vecs[5] = '{1'b1,  3,  9, 4, 16, 1'b1, ERRCNT_ON};

    for (int i = 0; i < DW / 32; i++) exp_wdata[i*32 +: 32] = FILL;
    checks = 0; errors = 0; cyc = 0;
    stall = 1'b0; err_burst = -1;
    resetn = 1'b0; erase_ram = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    erase_ram1 = 1'b0; awready1 = 1'b1; wready1 = 1'b1; bvalid1 = 1'b0; bresp1 = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_erase_idle", 64'(erase_idle), 64'(1));
    check("rst_erase_error", 64'(erase_error), 64'(0));
    check("rst_error_count", 64'(error_count), 64'(0));
    check("rst_awvalid", 64'(awvalid), 64'(0));
    check("rst_wvalid", 64'(wvalid), 64'(0));
    check("rst_bready", 64'(bready), 64'(0));
    check("rst_wlast", 64'(wlast), 64'(0));
    check("rst_awaddr", 64'(awaddr), 64'(0));
    check("awlen", 64'(awlen), 64'(BEATS - 1));
    check("awsize", 64'(awsize), 64'(6));
    check("awburst", 64'(awburst), 64'(1));
    check("wstrb_all_ones", 64'(&wstrb), 64'(1));

    resetn = 1'b1;
    step();
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of a sweep, then a clean restart.
    stall = 1'b0; err_burst = -1;
    erase_ram = 1'b1;
    step();
    erase_ram = 1'b0;
    n = 0;
    while (sw_w < 6 && n < 500) begin
      step();
      n++;
    end
    check("rst_mid_reached_beat6", 64'(sw_w >= 6), 64'(1));
    #1 resetn = 1'b0;
    #1;
    check("rst_mid_erase_idle", 64'(erase_idle), 64'(1));
    check("rst_mid_awvalid", 64'(awvalid), 64'(0));
    check("rst_mid_wvalid", 64'(wvalid), 64'(0));
    check("rst_mid_bready", 64'(bready), 64'(0));
    check("rst_mid_wlast", 64'(wlast), 64'(0));
    check("rst_mid_awaddr", 64'(awaddr), 64'(0));
    bq.delete();
    bvalid = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
    run_vec(vecs[0], 6);

    // Single outstanding burst: AWVALID only while no burst awaits its response.
    a1 = 0; b1 = 0; done1 = 1'b0;
    erase_ram1 = 1'b1;
    for (int c = 0; c < 400 && !done1; c++) begin
      @(negedge clk);
      if (awvalid1) check("mo1_no_aw_while_pending", 64'(a1 - b1), 64'(0));
      af = awvalid1 && awready1;
      wf = wvalid1 && wready1 && wlast1;
      bf = bvalid1 && bready1;
      if (af) begin
        check("mo1_addr", 64'(awaddr1), BASE + 64'(a1 * BB));
        a1++;
      end
      if (bf) b1++;
      @(posedge clk);
      #1;
      erase_ram1 = 1'b0;
      if (bf) bvalid1 = 1'b0;
      if (wf) q1.push_back(c + 10);
      if (!bvalid1 && q1.size() > 0 && c >= q1[0]) begin
        bvalid1 = 1'b1;
        q1.delete(0);
      end
      if (b1 == NB) done1 = 1'b1;
    end
    check("mo1_done", 64'(done1), 64'(1));
    check("mo1_bursts", 64'(a1), 64'(NB));
    @(negedge clk);
    check("mo1_idle", 64'(erase_idle1), 64'(1));
    check("mo1_error", 64'(erase_error1), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_erase_ctl.md
# ram_erase_ctl

AXI4 write-master sequencer that fills one RAM bank with a fixed value on command. It sits between `sys_control` and the bank's AXI4 write port. A one-cycle `erase_ram` strobe starts a sweep of write bursts covering the bank, and `erase_idle` reports completion back to the capture start-up sequence. Read channels are not implemented.

## Interface
- `DW`, 512: AXI data width in bits; power of 2, 32..1024.
- `AW`, 34: AXI address width.
- `RAM_BASE`, 0: byte address of the first location erased.
- `RAM_SIZE`, 2**33: bytes to erase; must be a multiple of `BURST_BEATS*DW/8`.
- `BURST_BEATS`, 64: beats per burst, 1..256.
- `MAX_OUT`, 8: maximum bursts with AW accepted but B not yet received, 1..255.
- `FILL_VALUE`, 32'h0: 32-bit word replicated across `wdata`.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `erase_ram` in 1: start strobe.
- `erase_idle` out 1: 1 = no erase in progress.
- `erase_error` out 1: sticky; set when any B response is not OKAY.
- `error_count` out 32: count of non-OKAY B responses (see Configuration).
- `M_AXI_AWADDR` out AW; `M_AXI_AWLEN` out 8; `M_AXI_AWSIZE` out 3; `M_AXI_AWBURST` out 2; `M_AXI_AWVALID` out 1; `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out DW; `M_AXI_WSTRB` out DW/8; `M_AXI_WLAST` out 1; `M_AXI_WVALID` out 1; `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2; `M_AXI_BVALID` in 1; `M_AXI_BREADY` out 1.

## Operation
- Derived values:
  - Burst bytes are `BB = BURST_BEATS*DW/8`.
  - Total bursts are `N = RAM_SIZE/BB`.
  - Counters are 32 bits wide.
- Constant outputs:
  - `AWLEN = BURST_BEATS-1`, `AWSIZE = log2(DW/8)`, `AWBURST = 2'b01` (INCR).
  - `WSTRB` is all ones; `WDATA = {DW/32{FILL_VALUE}}`.
- States:
  - IDLE: `erase_idle=1` and `BREADY=0`.
    - `erase_ram=1` → RUN. Clears `aw_cnt`, `w_cnt`, `beat`, `b_cnt` and `erase_error`.
    - `erase_ram` in any other state is ignored.
  - RUN: AW, W and B engines operate concurrently, as described below.
    - → IDLE when `b_cnt==N` on the cycle after the final B handshake.
- AW engine:
  - Asserts AWVALID while `aw_cnt<N` and `(aw_cnt-b_cnt)<MAX_OUT`.
  - `AWADDR = RAM_BASE + aw_cnt*BB`.
  - Increments `aw_cnt` on AWVALID&AWREADY.
- W engine:
  - Asserts WVALID while `w_cnt<aw_cnt`; write data never leads its address.
  - `beat` counts 0..BURST_BEATS-1; WLAST is asserted at `beat==BURST_BEATS-1`.
  - A handshake with WLAST resets `beat` to 0 and increments `w_cnt`.
- B engine:
  - BREADY is 1 throughout RUN.
  - Each handshake increments `b_cnt`.
  - BRESP≠0 sets `erase_error`.
- VALID rule: once asserted, AWVALID and WVALID stay high, with address/data stable, until their handshake. They are not deasserted mid-burst.
- Reset:
  - Asynchronous assertion forces IDLE immediately, from any state including mid-burst.
  - Reset values: `erase_idle=1`, `erase_error=0`, `error_count=0`, AWVALID=WVALID=BREADY=WLAST=0, AWADDR=0.
  - The downstream interconnect shares this reset.

## Timing
- `erase_ram` is sampled at cycle T. `erase_idle` is 0 from cycle T+1. AWVALID is 1 at T+1 provided `N>0`.
  - With `N=0` the block stays in IDLE; `erase_idle` never drops.
- The first WVALID is asserted no earlier than the cycle after the first AW handshake.
- All AXI outputs are registered, with no combinational path from any READY input to any VALID output.
- With READY held high and `MAX_OUT≥2`, throughput is one W beat per cycle.
- The final B handshake occurs at cycle F. `erase_idle=1` at F+1.
- AW and B handshakes on the same cycle update both counters correctly; the outstanding count is unchanged.

## Configuration
- `RAM_ERASE_ERRCNT_EN` defined:
  - `error_count` increments on each non-OKAY B handshake, saturating at 32'hFFFFFFFF.
  - It clears on start.
- Not defined:
  - `error_count` is tied to 0 and its counter logic is removed.
  - `erase_error` is still implemented.

## Test plan
All scenarios use `DW=512`, `BURST_BEATS=4`, `RAM_SIZE=1024`, `RAM_BASE=32'h1000` unless stated; this gives N=4 bursts.
- Ready always high, strobe at T → 4 AW handshakes at `AWADDR` 0x1000, 0x1100, 0x1200, 0x1300; 16 W beats; WLAST on beats 3, 7, 11, 15; `erase_idle` rises the cycle after the 4th B; `erase_error=0`.
- `MAX_OUT=1`, B returned 10 cycles after each WLAST → AWVALID never asserts while a burst awaits B; at most 1 outstanding.
- Random AWREADY/WREADY stalls at 50% → VALID and payload stay stable under stall; exactly 16 beats; `w_cnt` never exceeds `aw_cnt`.
- Burst 2 returns BRESP=2'b10 → `erase_error=1` and the sweep completes. With the macro defined, `error_count=1`; without it, 0. A following erase clears both.
- `resetn` asserted after beat 6 → `erase_idle=1` and all VALIDs 0 immediately. A new strobe after reset restarts at 0x1000.
- `erase_ram` pulsed again mid-sweep → ignored; exactly 4 bursts are issued.
